// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand capture, forwarding and 2-entry skid buffer in front of the ALU
module alu_operand_stage #(
  parameter int WIDTH  = 32,
  parameter int IMM_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs_addr,
  input  logic [REG_AW-1:0] in_rt_addr,
  input  logic [WIDTH-1:0]  in_rs_data,
  input  logic [WIDTH-1:0]  in_rt_data,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_alu_op,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              in_reg_write,
  input  logic              fwd_valid,
  input  logic [REG_AW-1:0] fwd_addr,
  input  logic [WIDTH-1:0]  fwd_data,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [2:0]        alu_select,
  output logic              alu_c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_reg_write
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [2:0]        sel;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              ui;
  } entry_t;
  state_t state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, cap, main_s, skid_s;
  logic in_ready_q, acc, take, fwd_live;
  assign fwd_live = fwd_valid && fwd_addr != '0;
  // held entries pick up write-backs so they never go stale while stalled
  function automatic entry_t snoop(input entry_t e, input logic hit, input logic [REG_AW-1:0] addr,
                                   input logic [WIDTH-1:0] data);
    entry_t r;
    r = e;
    if (hit && addr == e.rs) r.a = data;
    if (hit && !e.ui && addr == e.rt) r.b = data;
    return r;
  endfunction
  assign main_s = snoop(main_q, fwd_live, fwd_addr, fwd_data);
  assign skid_s = snoop(skid_q, fwd_live, fwd_addr, fwd_data);
  always_comb begin
    cap.a   = (fwd_live && fwd_addr == in_rs_addr) ? fwd_data : in_rs_data;
    cap.b   = in_use_imm ? {{(WIDTH-IMM_W){in_imm[IMM_W-1]}}, in_imm}
            : (fwd_live && fwd_addr == in_rt_addr) ? fwd_data : in_rt_data;
    cap.sel = in_alu_op;
    cap.rd  = in_rd_addr;
    cap.rw  = in_reg_write;
    cap.rs  = in_rs_addr;
    cap.rt  = in_rt_addr;
    cap.ui  = in_use_imm;
  end
  assign acc       = in_valid && in_ready_q;
  assign out_valid = state_q != EMPTY;
  assign take      = out_valid && out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_s;
    skid_d  = skid_s;
    if (flush) state_d = EMPTY;
    else if (state_q == EMPTY) begin
      if (acc) begin
        state_d = ONE;
        main_d  = cap;
      end
    end else if (state_q == ONE) begin
      if (acc && !take) begin
        state_d = TWO;
        skid_d  = cap;
      end else if (acc) main_d = cap;
      else if (take) state_d = EMPTY;
    end else if (take) begin
      state_d = ONE;
      main_d  = skid_s;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= state_d != TWO;
    end
  end
  assign in_ready      = in_ready_q;
  assign alu_a         = main_q.a;
  assign alu_b         = main_q.b;
  assign alu_select    = main_q.sel;
  assign alu_c_in      = 1'b0;
  assign out_rd_addr   = main_q.rd;
  assign out_reg_write = main_q.rw;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: scoreboard bench for the ALU operand stage
module tb_alu_operand_stage;
  logic        clk = 0, rst = 1, flush = 0, in_valid = 0, in_use_imm = 0, in_reg_write = 0;
  logic        fwd_valid = 0, out_ready = 0;
  logic [4:0]  in_rs_addr = 0, in_rt_addr = 0, in_rd_addr = 0, fwd_addr = 0;
  logic [31:0] in_rs_data = 0, in_rt_data = 0, fwd_data = 0;
  logic [15:0] in_imm = 0;
  logic [2:0]  in_alu_op = 0;
  logic        in_ready, alu_c_in, out_valid, out_reg_write;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_select;
  logic [4:0]  out_rd_addr;
  int checks = 0, failures = 0;
  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  sel;
    logic [4:0]  rd, rs, rt;
    logic        rw, ui;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  alu_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rs_data(in_rs_data),
    .in_rt_data(in_rt_data), .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_op(in_alu_op),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_select(alu_select), .alu_c_in(alu_c_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                    input logic [31:0] rtd, input logic ui, input logic [15:0] imm,
                    input logic [2:0] sel, input logic [4:0] rd);
    in_valid = 1; in_rs_addr = rs; in_rs_data = rsd; in_rt_addr = rt; in_rt_data = rtd;
    in_use_imm = ui; in_imm = imm; in_alu_op = sel; in_rd_addr = rd; in_reg_write = rd != 0;
  endtask
  task automatic fwd(input logic v, input logic [4:0] addr, input logic [31:0] data);
    fwd_valid = v; fwd_addr = addr; fwd_data = data;
  endtask
  always @(negedge clk) begin
    if (rst || flush) sb.delete();
    else begin
      chk("out_valid", out_valid, sb.size() != 0);
      chk("in_ready", in_ready, sb.size() < 2);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sb_a", alu_a, e.a);
          chk("sb_b", alu_b, e.b);
          chk("sb_sel", alu_select, e.sel);
          chk("sb_rd", out_rd_addr, e.rd);
          chk("sb_rw", out_reg_write, e.rw);
          chk("sb_cin", alu_c_in, 0);
        end
      end
      if (fwd_valid && fwd_addr != 0)
        foreach (sb[i]) begin
          if (sb[i].rs == fwd_addr) sb[i].a = fwd_data;
          if (!sb[i].ui && sb[i].rt == fwd_addr) sb[i].b = fwd_data;
        end
      if (in_valid && in_ready) begin
        e.rs = in_rs_addr; e.rt = in_rt_addr; e.ui = in_use_imm;
        e.sel = in_alu_op; e.rd = in_rd_addr; e.rw = in_reg_write;
        e.a = (fwd_valid && fwd_addr != 0 && fwd_addr == in_rs_addr) ? fwd_data : in_rs_data;
        e.b = in_use_imm ? {{16{in_imm[15]}}, in_imm}
            : (fwd_valid && fwd_addr != 0 && fwd_addr == in_rt_addr) ? fwd_data : in_rt_data;
        sb.push_back(e);
      end
    end
  end
  initial begin
    repeat (3) cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_sel", alu_select, 0);
    chk("rst_rd", out_rd_addr, 0);
    chk("rst_rw", out_reg_write, 0);
    rst = 0;
    out_ready = 1;
    op(5, 7, 6, 9, 0, 0, 3'b000, 1);
    cyc();
    in_valid = 0;
    chk("t1_valid", out_valid, 1);
    chk("t1_a", alu_a, 7);
    chk("t1_b", alu_b, 9);
    chk("t1_sel", alu_select, 0);
    chk("t1_cin", alu_c_in, 0);
    op(1, 1, 2, 2, 1, 16'hFFFE, 3'b001, 2);
    cyc();
    chk("t2_neg", alu_b, 32'hFFFF_FFFE);
    op(1, 1, 2, 2, 1, 16'h7FFF, 3'b010, 3);
    cyc();
    in_valid = 0;
    chk("t2_pos", alu_b, 32'h0000_7FFF);
    cyc();
    out_ready = 0;
    op(1, 32'h11, 2, 32'h12, 0, 0, 3'b011, 4);
    cyc();
    op(1, 32'h21, 2, 32'h22, 0, 0, 3'b100, 5);
    cyc();
    chk("t3_full", in_ready, 0);
    op(1, 32'h31, 2, 32'h32, 0, 0, 3'b101, 6);
    cyc();
    chk("t3_hold_rdy", in_ready, 0);
    chk("t3_hold_a", alu_a, 32'h11);
    in_valid = 0;
    out_ready = 1;
    repeat (3) cyc();
    chk("t3_drained", out_valid, 0);
    op(3, 32'h1111, 0, 0, 0, 0, 3'b000, 7);
    fwd(1, 3, 32'hABCD);
    cyc();
    chk("t4_fwd", alu_a, 32'hABCD);
    op(0, 0, 0, 0, 0, 0, 3'b000, 8);
    fwd(1, 0, 32'h77);
    cyc();
    in_valid = 0;
    fwd(0, 0, 0);
    chk("t4_zero", alu_a, 0);
    cyc();
    out_ready = 0;
    op(2, 32'h3, 4, 32'h10, 0, 0, 3'b000, 9);
    cyc();
    in_valid = 0;
    chk("t5_pre", alu_b, 32'h10);
    fwd(1, 4, 32'h55);
    cyc();
    fwd(0, 0, 0);
    chk("t5_snoop", alu_b, 32'h55);
    out_ready = 1;
    cyc();
    out_ready = 0;
    op(2, 32'h3, 4, 32'h10, 1, 16'h22, 3'b000, 10);
    cyc();
    in_valid = 0;
    fwd(1, 4, 32'h99);
    cyc();
    chk("t5_imm_keep", alu_b, 32'h22);
    fwd(1, 2, 32'h66);
    cyc();
    fwd(0, 0, 0);
    chk("t5_snoop_a", alu_a, 32'h66);
    out_ready = 1;
    cyc();
    out_ready = 0;
    op(1, 32'h41, 2, 32'h42, 0, 0, 3'b001, 11);
    cyc();
    op(1, 32'h51, 2, 32'h52, 0, 0, 3'b001, 12);
    cyc();
    op(1, 32'h61, 2, 32'h62, 0, 0, 3'b001, 13);
    flush = 1;
    cyc();
    flush = 0;
    in_valid = 0;
    chk("t6_valid", out_valid, 0);
    chk("t6_ready", in_ready, 1);
    op(1, 32'h71, 2, 32'h72, 0, 0, 3'b001, 14);
    cyc();
    op(1, 32'h81, 2, 32'h82, 0, 0, 3'b001, 15);
    flush = 1;
    cyc();
    flush = 0;
    in_valid = 0;
    chk("t6_one_valid", out_valid, 0);
    out_ready = 1;
    repeat (3) cyc();
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 1);
      in_rs_addr = 5'($urandom_range(0, 7));
      in_rt_addr = 5'($urandom_range(0, 7));
      in_rs_data = in_rs_addr == 0 ? 0 : $urandom;
      in_rt_data = in_rt_addr == 0 ? 0 : $urandom;
      in_imm = 16'($urandom);
      in_use_imm = $urandom_range(0, 1);
      in_alu_op = 3'($urandom);
      in_rd_addr = 5'($urandom);
      in_reg_write = $urandom_range(0, 1);
      fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      out_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    in_valid = 0;
    fwd(0, 0, 0);
    out_ready = 1;
    repeat (4) cyc();
    chk("final_empty", out_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
